// File: rtl/sign_ctrl_pkg.sv
// Shared widths, operand/product types and sign helpers for the signed
// wrapper around the unsigned multiplier core.
package sign_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef logic [WIDTH_DEF-1:0]   opnd_t;
  typedef logic [2*WIDTH_DEF-1:0] prod_t;

  // -2^(W-1) maps to 2^(W-1), which still fits unsigned in W bits.
  function automatic opnd_t abs_val(input opnd_t v);
    return v[WIDTH_DEF-1] ? (~v + opnd_t'(1)) : v;
  endfunction

  function automatic prod_t neg_prod(input prod_t p);
    return ~p + prod_t'(1);
  endfunction
endpackage

// File: rtl/sign_fifo.sv
// DEPTH x 1-bit FIFO carrying product signs from issue to return.
module sign_fifo
  import sign_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        din,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign full   = (r_cnt == CNT_MAX);
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_ONE;
    end
  end
endmodule

// File: rtl/sign_ctrl_stage.sv
// Signed front/back end for the unsigned multiplier core: strips signs on
// issue, queues the product sign, and re-applies it to returning products.
module sign_ctrl_stage
  import sign_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               core_valid,
  input  logic               core_ready,
  output logic [WIDTH-1:0]   core_a,
  output logic [WIDTH-1:0]   core_b,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [2*WIDTH-1:0] res_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = 1;
  localparam logic [PW-1:0]    ONE_P = 1;

  logic             r_core_valid, r_out_valid, r_err;
  logic [WIDTH-1:0] r_core_a, r_core_b;
  logic [PW-1:0]    r_out_p;

  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [PW-1:0]    w_neg_p;
  logic             w_in_ready, w_in_fire, w_res_ready, w_res_fire, w_pop;
  logic             w_sign, w_full, w_empty;
  logic [AW:0]      w_cnt;

  generate
    if (WIDTH == WIDTH_DEF) begin : g_pkg
      assign w_abs_a = abs_val(in_a);
      assign w_abs_b = abs_val(in_b);
      assign w_neg_p = neg_prod(res_p);
    end else begin : g_gen
      assign w_abs_a = in_a[WIDTH-1] ? (~in_a + ONE_W) : in_a;
      assign w_abs_b = in_b[WIDTH-1] ? (~in_b + ONE_W) : in_b;
      assign w_neg_p = ~res_p + ONE_P;
    end
  endgenerate

  // A full FIFO blocks issue even if a pop lands on the same edge.
  assign w_in_ready  = (!r_core_valid || core_ready) && !w_full;
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_res_ready = !r_out_valid || out_ready;
  assign w_res_fire  = res_valid && w_res_ready;
  assign w_pop       = w_res_fire && (w_cnt != '0);

  sign_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_in_fire),
    .pop   (w_pop),
    .din   (in_a[WIDTH-1] ^ in_b[WIDTH-1]),
    .dout  (w_sign),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_valid <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
    end else if (w_in_fire) begin
      r_core_valid <= 1'b1;
      r_core_a     <= w_abs_a;
      r_core_b     <= w_abs_b;
    end else if (core_ready) begin
      r_core_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_p     <= w_sign ? w_neg_p : res_p;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A product with no queued sign is swallowed and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_err <= 1'b0;
    else if (w_res_fire && w_empty) r_err <= 1'b1;
  end

  assign in_ready   = w_in_ready;
  assign res_ready  = w_res_ready;
  assign core_valid = r_core_valid;
  assign core_a     = r_core_a;
  assign core_b     = r_core_b;
  assign out_valid  = r_out_valid;
  assign out_p      = r_out_p;
  assign err        = r_err;
endmodule

// File: tb/tb_sign_ctrl_stage.sv
// Bench for sign_ctrl_stage: randomized traffic through a latency-modelled
// core, checked every cycle against a queue-based model of the signed path.
module tb_sign_ctrl_stage;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          core_valid, core_ready = 1'b0;
  logic [W-1:0]  core_a, core_b;
  logic          res_valid = 1'b0, res_ready;
  logic [PW-1:0] res_p = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [PW-1:0] out_p;
  logic          err;

  always #5 clk = ~clk;

  sign_ctrl_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_valid(core_valid), .core_ready(core_ready), .core_a(core_a), .core_b(core_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .err(err)
  );

  int npass = 0, ntot = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Model state: ops the core still owes, signs awaiting a result, end-to-end products.
  typedef struct { int due; logic [PW-1:0] p; } core_t;
  core_t         core_q[$];
  logic          sign_q[$];
  logic [PW-1:0] e2e_q[$];
  logic          core_held = 0, out_held = 0, exp_err = 0;
  logic [W-1:0]  hold_ca, hold_cb;
  logic [PW-1:0] hold_p;
  int            cyc = 0, lat = 1;
  logic          res_en = 1, spur = 0;

  // Core stand-in: returns |a|*|b| in issue order after 'lat' cycles.
  always @(posedge clk) begin
    #1;
    if (spur) begin
      res_valid = 1'b1; res_p = 16'h1234;
    end else if (res_en && core_q.size() > 0 && core_q[0].due <= cyc) begin
      res_valid = 1'b1; res_p = core_q[0].p;
    end else begin
      res_valid = 1'b0; res_p = '0;
    end
  end

  always @(negedge clk) begin
    logic inf, cf, rf, of, s;
    int sa, sb, rp;
    core_t c;
    cyc++;
    if (!rst_n) begin
      chk("rst core_valid", core_valid, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst err", err, 0);
      chk("rst core_a", core_a, 0);
      chk("rst core_b", core_b, 0);
      chk("rst out_p", out_p, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst count", dut.w_cnt, 0);
      core_q.delete(); sign_q.delete(); e2e_q.delete();
      core_held = 0; out_held = 0; exp_err = 0;
    end else begin
      chk("core_valid", core_valid, core_held);
      chk("out_valid", out_valid, out_held);
      chk("err", err, exp_err);
      if (core_held) begin
        chk("core_a", core_a, hold_ca);
        chk("core_b", core_b, hold_cb);
      end
      if (out_held) chk("out_p", out_p, hold_p);
      chk("in_ready", in_ready, (!core_held || core_ready) && sign_q.size() != D);
      chk("res_ready", res_ready, !out_held || out_ready);

      inf = in_valid && (!core_held || core_ready) && sign_q.size() != D;
      cf  = core_held && core_ready;
      rf  = res_valid && (!out_held || out_ready);
      of  = out_held && out_ready;

      if (of) begin
        if (e2e_q.size() > 0) chk("e2e product", out_p, e2e_q.pop_front());
        else chk("e2e extra output", 1, 0);
        out_held = 0;
      end
      if (rf) begin
        if (sign_q.size() > 0) begin
          s  = sign_q.pop_front();
          rp = int'(res_p);
          hold_p   = s ? PW'((1 << PW) - rp) : res_p;
          out_held = 1;
        end else begin
          exp_err = 1;
        end
        if (!spur && core_q.size() > 0) void'(core_q.pop_front());
      end
      if (cf) begin
        c.due = cyc + lat;
        c.p   = PW'(int'(hold_ca) * int'(hold_cb));
        core_q.push_back(c);
        core_held = 0;
      end
      if (inf) begin
        sa = $signed(in_a); sb = $signed(in_b);
        hold_ca = W'(sa < 0 ? -sa : sa);
        hold_cb = W'(sb < 0 ? -sb : sb);
        core_held = 1;
        sign_q.push_back((sa < 0) != (sb < 0));
        e2e_q.push_back(PW'(sa * sb));
      end
    end
  end

  task automatic lit(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ca, input logic [W-1:0] cb,
                     input logic [PW-1:0] op);
    int t;
    @(posedge clk); #2 in_valid = 1; in_a = a; in_b = b; core_ready = 0; out_ready = 0;
    @(posedge clk); #2 in_valid = 0;
    @(negedge clk);
    chk("lit core_a", core_a, ca);
    chk("lit core_b", core_b, cb);
    @(posedge clk); #2 core_ready = 1;
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    chk("lit out_valid", out_valid, 1);
    chk("lit out_p", out_p, op);
    @(posedge clk); #2 out_ready = 1;
    @(posedge clk); #2 out_ready = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    lit(-8'sd3, 8'sd5, 8'd3, 8'd5, 16'hFFF1);
    lit(8'h80, 8'h80, 8'd128, 8'd128, 16'h4000);
    lit(8'd0, -8'sd7, 8'd0, 8'd7, 16'h0000);

    // Reset with three ops in flight.
    @(posedge clk); #2 res_en = 0; core_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_a = W'($urandom); in_b = W'($urandom);
      @(posedge clk); #2;
    end
    in_valid = 0; rst_n = 0;
    #1 chk("async rst core_valid", core_valid, 0);
    @(posedge clk); #2 rst_n = 1;

    // Back-pressure: four accepted, fifth waits for one result.
    @(posedge clk); #2 in_valid = 1; in_a = 8'hF9; in_b = 8'h0B;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("bp in_ready after 4", in_ready, 0);
    @(posedge clk); #2 res_en = 1;
    @(posedge clk); #2 res_en = 0;
    @(negedge clk); chk("bp full with pop", in_ready, 0);
    @(negedge clk); chk("bp reopen", in_ready, 1);
    @(posedge clk); #2 in_valid = 0; res_en = 1;

    // Output stall: result held, core result blocked.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall out_valid", out_valid, 1);
    chk("stall res_ready", res_ready, 0);
    @(posedge clk); #2 out_ready = 1;
    repeat (20) @(posedge clk);

    // Core stall for three cycles.
    #2 in_valid = 1; in_a = 8'h9C; in_b = 8'h21; core_ready = 0;
    @(posedge clk); #2 in_valid = 0;
    repeat (3) @(posedge clk);
    #2 core_ready = 1;
    repeat (10) @(posedge clk);

    // Randomized streaming through a 2-cycle core.
    #2 lat = 2;
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 1) == 1);
      in_a       = W'($urandom);
      in_b       = W'($urandom);
      core_ready = ($urandom_range(0, 3) != 0);
      res_en     = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) == 0) ? out_ready : ~out_ready;
      @(posedge clk); #2;
    end
    in_valid = 0; core_ready = 1; res_en = 1; out_ready = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("drain e2e", e2e_q.size(), 0);
    chk("drain signs", sign_q.size(), 0);
    chk("drain out_valid", out_valid, 0);
    chk("drain err", err, 0);

    // Spurious result with nothing in flight.
    @(posedge clk); #2 spur = 1;
    @(posedge clk); #2 spur = 0;
    @(negedge clk); chk("spur res_ready", res_ready, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("spur err sticky", err, 1);
    chk("spur out_valid", out_valid, 0);
    @(posedge clk); #2 rst_n = 0;
    @(negedge clk); chk("spur err cleared", err, 0);
    @(posedge clk); #2 rst_n = 1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
